// File: rtl/cmd_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : cmd_frame_parser
// Purpose  : Turns a strobed byte stream into single-cycle register-file and
//            ALU requests, with an inter-byte timeout that aborts stalled frames.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_frame_parser #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  alu_en,
  output logic [3:0]            alu_fun,
  output logic [DATA_WIDTH-1:0] alu_op_a,
  output logic [DATA_WIDTH-1:0] alu_op_b,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  frame_err
);

  localparam int                  c_tmo_w    = $clog2(TIMEOUT);
  localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_tmo_w-1:0]  c_tmo_one  = c_tmo_w'(1);
  localparam logic [DATA_WIDTH-1:0] c_cmd_wr     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] c_cmd_rd     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] c_cmd_alu_op = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] c_cmd_alu    = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_ALU_A   = 3'd4,
    S_ALU_B   = 3'd5,
    S_ALU_FUN = 3'd6
  } t_state;

  t_state             r_state;
  logic [c_tmo_w-1:0] r_tmo_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      alu_en    <= 1'b0;
      alu_fun   <= '0;
      alu_op_a  <= '0;
      alu_op_b  <= '0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      alu_en    <= 1'b0;
      cmd_err   <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid) begin
        // An arriving byte always beats a timeout landing on the same cycle.
        r_tmo_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            case (rx_data)
              c_cmd_wr:     begin r_state <= S_WR_ADDR; busy <= 1'b1; end
              c_cmd_rd:     begin r_state <= S_RD_ADDR; busy <= 1'b1; end
              c_cmd_alu_op: begin r_state <= S_ALU_A;   busy <= 1'b1; end
              c_cmd_alu:    begin r_state <= S_ALU_FUN; busy <= 1'b1; end
              default:      cmd_err <= 1'b1;
            endcase
          end
          S_WR_ADDR: begin
            addr    <= rx_data[ADDR_WIDTH-1:0];
            r_state <= S_WR_DATA;
          end
          S_WR_DATA: begin
            wr_data <= rx_data;
            wr_en   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          S_RD_ADDR: begin
            addr    <= rx_data[ADDR_WIDTH-1:0];
            rd_en   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ALU_A: begin
            alu_op_a <= rx_data;
            r_state  <= S_ALU_B;
          end
          S_ALU_B: begin
            alu_op_b <= rx_data;
            r_state  <= S_ALU_FUN;
          end
          S_ALU_FUN: begin
            alu_fun <= rx_data[3:0];
            alu_en  <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tmo_cnt == c_tmo_last) begin
          r_tmo_cnt <= '0;
          frame_err <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
        end
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_frame_parser
// Purpose  : Directed self-checking bench; a frame-level model is compared
//            against the parser every cycle, plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_parser;

  localparam int c_tmo = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_en, rd_en, alu_en, busy, cmd_err, frame_err;
  logic [3:0] addr, alu_fun;
  logic [7:0] wr_data, alu_op_a, alu_op_b;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b0;

  cmd_frame_parser #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .TIMEOUT   (c_tmo)
  ) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .alu_en   (alu_en),
    .alu_fun  (alu_fun),
    .alu_op_a (alu_op_a),
    .alu_op_b (alu_op_b),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Frame-level model: collects the bytes of the current frame and derives
  // the outputs from the frame's command and byte position.
  logic [7:0] q[$];
  int         idle = 0;
  logic       m_wr_en = 0, m_rd_en = 0, m_alu_en = 0, m_busy = 0, m_cmd_err = 0, m_frame_err = 0;
  logic [3:0] m_addr = 0, m_alu_fun = 0;
  logic [7:0] m_wr_data = 0, m_op_a = 0, m_op_b = 0;

  function automatic int frame_len(input logic [7:0] cmd);
    case (cmd)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 0;
    endcase
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q.delete();
      idle = 0;
      {m_wr_en, m_rd_en, m_alu_en, m_busy, m_cmd_err, m_frame_err} = '0;
      m_addr = 0; m_alu_fun = 0; m_wr_data = 0; m_op_a = 0; m_op_b = 0;
    end else begin
      {m_wr_en, m_rd_en, m_alu_en, m_cmd_err, m_frame_err} = '0;
      if (rx_valid) begin
        idle = 0;
        if (q.size() == 0) begin
          if (frame_len(rx_data) != 0) q.push_back(rx_data);
          else m_cmd_err = 1'b1;
        end else begin
          q.push_back(rx_data);
          case ({q[0], 8'(q.size())})
            {8'hAA, 8'd2}: m_addr = rx_data[3:0];
            {8'hAA, 8'd3}: begin m_wr_data = rx_data; m_wr_en = 1'b1; end
            {8'hBB, 8'd2}: begin m_addr = rx_data[3:0]; m_rd_en = 1'b1; end
            {8'hCC, 8'd2}: m_op_a = rx_data;
            {8'hCC, 8'd3}: m_op_b = rx_data;
            {8'hCC, 8'd4}: begin m_alu_fun = rx_data[3:0]; m_alu_en = 1'b1; end
            {8'hDD, 8'd2}: begin m_alu_fun = rx_data[3:0]; m_alu_en = 1'b1; end
            default: ;
          endcase
          if (q.size() == frame_len(q[0])) q.delete();
        end
      end else if (q.size() != 0) begin
        idle++;
        if (idle == c_tmo) begin
          m_frame_err = 1'b1;
          q.delete();
          idle = 0;
        end
      end
      m_busy = (q.size() != 0);
    end
  end

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("wr_en",     32'(wr_en),     32'(m_wr_en));
      chk("rd_en",     32'(rd_en),     32'(m_rd_en));
      chk("alu_en",    32'(alu_en),    32'(m_alu_en));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("cmd_err",   32'(cmd_err),   32'(m_cmd_err));
      chk("frame_err", 32'(frame_err), 32'(m_frame_err));
      chk("addr",      32'(addr),      32'(m_addr));
      chk("wr_data",   32'(wr_data),   32'(m_wr_data));
      chk("alu_fun",   32'(alu_fun),   32'(m_alu_fun));
      chk("alu_op_a",  32'(alu_op_a),  32'(m_op_a));
      chk("alu_op_b",  32'(alu_op_b),  32'(m_op_b));
    end
  end

  // Called at a falling edge; presents one byte for exactly one rising edge.
  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = 8'hCC;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    idle_cyc(2);
    cmp_on = 1'b1;
    chk("reset_busy",  32'(busy),  32'h0);
    chk("reset_wr_en", 32'(wr_en), 32'h0);
    chk("reset_addr",  32'(addr),  32'h0);
    RST = 1'b1;
    idle_cyc(2);

    // Write frame
    put(8'hAA); put(8'h35); put(8'h5C);
    chk("wr_pulse", 32'(wr_en),   32'h1);
    chk("wr_addr",  32'(addr),    32'h5);
    chk("wr_data",  32'(wr_data), 32'h5C);
    idle_cyc(1);
    chk("wr_single", 32'(wr_en), 32'h0);
    chk("wr_busy",   32'(busy),  32'h0);

    // Read frame with the ALU command arriving while rd_en is high
    put(8'hBB); put(8'h0E);
    chk("rd_pulse", 32'(rd_en), 32'h1);
    chk("rd_addr",  32'(addr),  32'hE);
    put(8'hCC); put(8'h12); put(8'h34); put(8'h07);
    chk("alu_pulse", 32'(alu_en),   32'h1);
    chk("alu_a",     32'(alu_op_a), 32'h12);
    chk("alu_b",     32'(alu_op_b), 32'h34);
    chk("alu_fun",   32'(alu_fun),  32'h7);
    idle_cyc(2);

    // ALU without operands, then an unknown command
    put(8'hDD); put(8'h0A);
    chk("dd_pulse", 32'(alu_en),   32'h1);
    chk("dd_fun",   32'(alu_fun),  32'hA);
    chk("dd_a",     32'(alu_op_a), 32'h12);
    idle_cyc(1);
    put(8'h55);
    chk("cmd_err", 32'(cmd_err), 32'h1);
    chk("err_busy", 32'(busy),   32'h0);
    idle_cyc(2);

    // Payload 0xAA is data, not a command
    put(8'hAA); put(8'hAA); put(8'hBB);
    chk("payload_addr", 32'(addr),    32'hA);
    chk("payload_data", 32'(wr_data), 32'hBB);
    idle_cyc(2);

    // Timeout abort
    put(8'hAA); put(8'h03);
    idle_cyc(c_tmo - 1);
    chk("tmo_early", 32'(frame_err), 32'h0);
    chk("tmo_busy",  32'(busy),      32'h1);
    idle_cyc(1);
    chk("tmo_err",   32'(frame_err), 32'h1);
    chk("tmo_idle",  32'(busy),      32'h0);
    chk("tmo_addr",  32'(addr),      32'h3);
    chk("tmo_no_wr", 32'(wr_en),     32'h0);
    idle_cyc(3);

    // Byte lands exactly in the terminal cycle
    put(8'hAA); put(8'h09);
    idle_cyc(c_tmo - 1);
    put(8'h77);
    chk("edge_no_err", 32'(frame_err), 32'h0);
    chk("edge_wr",     32'(wr_en),     32'h1);
    chk("edge_data",   32'(wr_data),   32'h77);
    idle_cyc(3);

    // Asynchronous reset mid-frame
    put(8'hCC); put(8'h11);
    chk("pre_rst_a", 32'(alu_op_a), 32'h11);
    #2 RST = 1'b0;
    #1;
    chk("rst_a",    32'(alu_op_a), 32'h0);
    chk("rst_busy", 32'(busy),     32'h0);
    chk("rst_addr", 32'(addr),     32'h0);
    chk("rst_data", 32'(wr_data),  32'h0);
    idle_cyc(2);
    RST = 1'b1;
    idle_cyc(1);
    put(8'hBB); put(8'h02);
    chk("post_rst_rd",   32'(rd_en), 32'h1);
    chk("post_rst_addr", 32'(addr),  32'h2);
    idle_cyc(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_frame_parser.md
Name: cmd_frame_parser

Overview:
- Consumes the synchronized byte stream from the data synchronizer: the 8-bit bus plus its one-cycle enable pulse.
- Assembles multi-byte command frames and issues single-cycle register-file read/write and ALU requests.
- Sits in the system-clock domain, directly downstream of the synchronizer and upstream of the register file and ALU.
- Includes an inter-byte timeout so that a truncated frame cannot hang the parser.

Parameters:
- DATA_WIDTH, 8, width of rx_data, wr_data, alu_op_a and alu_op_b.
- ADDR_WIDTH, 4, register-file address width; taken from the LSBs of the address byte.
- TIMEOUT, 1024, idle cycles allowed between bytes of one frame before abort; must be >= 2.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  asynchronous active-low reset.
- rx_data  input  DATA_WIDTH  synchronized byte; valid only when rx_valid=1.
- rx_valid  input  1  single-cycle byte strobe from the synchronizer.
- wr_en  output  1  one-cycle register write request.
- rd_en  output  1  one-cycle register read request.
- addr  output  ADDR_WIDTH  register address for wr_en/rd_en.
- wr_data  output  DATA_WIDTH  write data.
- alu_en  output  1  one-cycle ALU request.
- alu_fun  output  4  ALU function code.
- alu_op_a  output  DATA_WIDTH  ALU operand A.
- alu_op_b  output  DATA_WIDTH  ALU operand B.
- busy  output  1  high while a frame is in progress (state != IDLE).
- cmd_err  output  1  one-cycle pulse when an unknown command byte arrives in IDLE.
- frame_err  output  1  one-cycle pulse when a timeout aborts a frame.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; every output 0, including addr, wr_data, alu_fun, alu_op_a, alu_op_b and busy; timeout counter 0.
- All outputs are registered. Request strobes assert exactly one cycle after the rx_valid of the final frame byte, for exactly one cycle.
- Bytes are accepted only on rx_valid=1; rx_data is ignored otherwise.
- Command bytes, decoded in IDLE:
  - 0xAA = write: IDLE->WR_ADDR->WR_DATA.
  - 0xBB = read: IDLE->RD_ADDR.
  - 0xCC = ALU with operands: IDLE->ALU_A->ALU_B->ALU_FUN.
  - 0xDD = ALU without operands: IDLE->ALU_FUN.
- Any other byte in IDLE: stay in IDLE, pulse cmd_err; all other outputs unchanged.
- WR_ADDR: byte -> addr <= byte[ADDR_WIDTH-1:0]; go to WR_DATA.
- WR_DATA: byte -> wr_data <= byte, wr_en pulse; go to IDLE.
- RD_ADDR: byte -> addr <= byte[ADDR_WIDTH-1:0], rd_en pulse; go to IDLE.
- ALU_A: byte -> alu_op_a <= byte; go to ALU_B.
- ALU_B: byte -> alu_op_b <= byte; go to ALU_FUN.
- ALU_FUN: byte -> alu_fun <= byte[3:0], alu_en pulse; go to IDLE.
- Operand and address hold: under 0xDD, alu_op_a/alu_op_b keep their last values. addr, wr_data and the operands hold between frames.
- Payload bytes are data, never commands: a value of 0xAA received in WR_ADDR is an address.
- Timeout counter, width $clog2(TIMEOUT):
  - cleared on every accepted byte and while in IDLE;
  - increments each non-IDLE cycle without rx_valid.
- Timeout abort: when the counter reaches TIMEOUT-1 with no rx_valid that cycle, go to IDLE and pulse frame_err. No request strobe is issued, and partially captured fields keep their new values.
- Byte and timeout in the same cycle: the byte wins; no frame_err.
- busy is registered: high from the cycle after the command byte until the cycle after the final byte or the abort.
- Back-to-back frames: a command byte is accepted on the very next rx_valid after a frame completes, even if that strobe arrives while wr_en/rd_en/alu_en is still high. There is no dead cycle.
- Reset mid-frame: immediate return to IDLE with all outputs cleared; no strobe and no error pulse.

Test Plan:
- Write frame: bytes 0xAA, 0x35, 0x5C → one cycle after the 0x5C strobe: wr_en=1 for 1 cycle, addr=0x5, wr_data=0x5C; busy=0 afterwards.
- Read frame followed immediately by an ALU-with-operands frame: 0xBB, 0x0E, 0xCC, 0x12, 0x34, 0x07 →
  - rd_en pulse with addr=0xE;
  - then alu_en pulse with alu_op_a=0x12, alu_op_b=0x34, alu_fun=0x7.
- Follow-up 0xDD, 0x0A → alu_en pulse with alu_fun=0xA and operands still 0x12/0x34. Then unknown byte 0x55 → cmd_err pulse; busy stays 0; no strobes.
- Timeout: TIMEOUT=16; send 0xAA, 0x03, then nothing → frame_err pulses 16 cycles after the 0x03 strobe; state returns to IDLE; wr_en never asserts; addr=0x3.
- Boundary: with the same TIMEOUT, deliver the next byte exactly in the terminal cycle → no frame_err; the frame completes normally.
- Reset mid-frame: assert RST=0 after 0xCC, 0x11 → all outputs 0 immediately (asynchronously). After release, 0xBB, 0x02 → rd_en pulse with addr=0x2.
